// File: rtl/pattern_stream_pkg.sv
// Shared definitions for the pattern stream controller.
//   - state_e    : controller FSM states (IDLE, SHIFT)
//   - DEF_*      : default word width, pattern length and pattern value
//   - clog2()    : ceiling log2, used to size det_pos and small counters
package pattern_stream_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int         DEF_DATA_W = 8;
  localparam int         DEF_PAT_W  = 4;
  localparam logic [3:0] DEF_PAT    = 4'b1010;
  localparam int         DEF_CNT_W  = 8;

  // Ceiling log2 with a floor of 1 so that derived vectors are never zero-width.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pattern_match_core.sv
// Serial pattern matcher (Mealy style).
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   bit_in        : serial bit presented this cycle
//   bit_en        : bit_in is valid this cycle (history advances only then)
//   overlap       : 1 = overlapping matches, 0 = history dropped after a match
//   clr           : synchronous clear of the history
//   match         : combinational, {history, bit_in} == PAT with full history
module pattern_match_core
  import pattern_stream_pkg::*;
#(
  parameter int               PAT_W = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PAT   = DEF_PAT
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_in,
  input  logic bit_en,
  input  logic overlap,
  input  logic clr,
  output logic match
);

  localparam int                HIST_W = PAT_W - 1;
  localparam int                VCNT_W = clog2(PAT_W);
  localparam logic [VCNT_W-1:0] FULL   = VCNT_W'(HIST_W);

  logic [HIST_W-1:0] hist_q, hist_d;
  logic [VCNT_W-1:0] vcnt_q, vcnt_d;
  logic [PAT_W-1:0]  window;

  // Oldest history bit lands in the MSB, matching the orientation of PAT.
  assign window = {hist_q, bit_in};
  assign match  = bit_en && (vcnt_q == FULL) && (window == PAT);

  always_comb begin
    hist_d = hist_q;
    vcnt_d = vcnt_q;
    if (clr) begin
      hist_d = '0;
      vcnt_d = '0;
    end else if (bit_en) begin
      if (match && !overlap) begin
        // Non-overlapping: the next match must be built from fresh bits.
        hist_d = '0;
        vcnt_d = '0;
      end else begin
        hist_d = window[HIST_W-1:0];
        if (vcnt_q != FULL) begin
          vcnt_d = vcnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      vcnt_q <= '0;
    end else begin
      hist_q <= hist_d;
      vcnt_q <= vcnt_d;
    end
  end

endmodule

// File: rtl/pattern_stream_ctrl.sv
// Word-stream front end for a serial pattern detector.
// Accepts DATA_W-bit words on a valid/ready handshake, serializes them
// MSB-first (one bit per clk, gapless when the producer keeps up), feeds the
// matcher core, counts matches (saturating) and raises a sticky irq.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   s_valid/s_ready   : word handshake; s_data bit DATA_W-1 goes out first
//   cfg_overlap       : overlapping (1) / non-overlapping (0) matching
//   cfg_thresh        : match count that sets irq (0 disables irq)
//   clr               : synchronous clear of count, irq and matcher history
//   det_pulse/det_pos : registered one-cycle match pulse and bit position
//   match_cnt         : saturating match count
//   irq               : sticky threshold interrupt
//   busy              : high while a word is being shifted
module pattern_stream_ctrl
  import pattern_stream_pkg::*;
#(
  parameter int               DATA_W = DEF_DATA_W,
  parameter int               PAT_W  = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PAT    = DEF_PAT,
  parameter int               CNT_W  = DEF_CNT_W,
  localparam int              POS_W  = clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              cfg_overlap,
  input  logic [CNT_W-1:0]  cfg_thresh,
  input  logic              clr,
  output logic              det_pulse,
  output logic [POS_W-1:0]  det_pos,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              irq,
  output logic              busy
);

  localparam logic [POS_W-1:0] LAST_IDX = POS_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  sreg_q, sreg_d;
  logic [POS_W-1:0]   bit_idx_q, bit_idx_d;
  logic               det_pulse_q, det_pulse_d;
  logic [POS_W-1:0]   det_pos_q, det_pos_d;
  logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
  logic               irq_q, irq_d;

  logic               last_bit;
  logic               hs;
  logic               core_match;
  logic               match_ok;
  logic [CNT_W-1:0]   cnt_inc;

  assign last_bit = (state_q == SHIFT) && (bit_idx_q == LAST_IDX);
  // Ready during the last serial bit lets the next word follow with no gap.
  assign s_ready  = rst && ((state_q == IDLE) || last_bit);
  assign hs       = s_valid && s_ready;
  assign busy     = (state_q == SHIFT);

  pattern_match_core #(
    .PAT_W (PAT_W),
    .PAT   (PAT)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .bit_in  (sreg_q[DATA_W-1]),
    .bit_en  (busy),
    .overlap (cfg_overlap),
    .clr     (clr),
    .match   (core_match)
  );

  // Serializer FSM.
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    bit_idx_d = bit_idx_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          sreg_d    = s_data;
          bit_idx_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        sreg_d    = {sreg_q[DATA_W-2:0], 1'b0};
        bit_idx_d = bit_idx_q + 1'b1;
        if (last_bit) begin
          bit_idx_d = '0;
          if (hs) begin
            sreg_d = s_data;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Match accounting. clr takes priority over a match in the same cycle.
  always_comb begin
    match_ok    = core_match && !clr;
    cnt_inc     = (match_cnt_q == CNT_MAX) ? match_cnt_q : match_cnt_q + 1'b1;
    det_pulse_d = match_ok;
    det_pos_d   = match_ok ? bit_idx_q : det_pos_q;
    match_cnt_d = match_cnt_q;
    irq_d       = irq_q;
    if (clr) begin
      match_cnt_d = '0;
      irq_d       = 1'b0;
    end else if (match_ok) begin
      match_cnt_d = cnt_inc;
      if ((cfg_thresh != '0) && (cnt_inc == cfg_thresh)) begin
        irq_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      bit_idx_q   <= '0;
      det_pulse_q <= 1'b0;
      det_pos_q   <= '0;
      match_cnt_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      bit_idx_q   <= bit_idx_d;
      det_pulse_q <= det_pulse_d;
      det_pos_q   <= det_pos_d;
      match_cnt_q <= match_cnt_d;
      irq_q       <= irq_d;
    end
  end

  assign det_pulse = det_pulse_q;
  assign det_pos   = det_pos_q;
  assign match_cnt = match_cnt_q;
  assign irq       = irq_q;

endmodule

// File: doc/pattern_stream_ctrl.md
Name: pattern_stream_ctrl

Overview:
Controller that feeds a serial pattern detector from a parallel word stream. It accepts DATA_W-bit words over a valid/ready handshake and serializes them MSB-first, one bit per clk, into an embedded overlapping/non-overlapping Mealy-style pattern matcher (default pattern 1010). It counts matches and raises a sticky threshold interrupt. It sits between a word-oriented producer and the status/interrupt logic that consumes detection events.

Parameters:
DATA_W, 8, width of input words
PAT_W, 4, pattern length in bits (2..DATA_W)
PAT, 4'b1010, pattern value; the MSB is the oldest bit
CNT_W, 8, width of the match counter and threshold

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  asynchronous, active-low reset
s_valid  in  1  producer has a word
s_ready  out  1  controller accepts a word this cycle
s_data  in  DATA_W  word; bit DATA_W-1 is serialized first
cfg_overlap  in  1  1 = overlapping matches; 0 = history cleared after each match
cfg_thresh  in  CNT_W  irq threshold; 0 disables irq
clr  in  1  synchronous clear of count, irq and detector history
det_pulse  out  1  one-cycle pulse per match (registered)
det_pos  out  clog2(DATA_W)  bit index within the word of the bit that completed the match (0 = MSB)
match_cnt  out  CNT_W  saturating match count
irq  out  1  sticky; set when match_cnt reaches cfg_thresh
busy  out  1  high in SHIFT

Behaviour:
- Reset (rst low, async):
  - state=IDLE.
  - det_pulse, det_pos, match_cnt, irq, busy, shift register, bit index and detector history all go to 0.
  - s_ready is forced 0 while rst is low.
- FSM states: IDLE, SHIFT.
  - IDLE: s_ready=1. On s_valid&&s_ready, load s_data into the shift register, set bit_idx=0 and go to SHIFT.
  - SHIFT: presents serial bit = sreg[DATA_W-1] each cycle and shifts left; bit_idx increments each cycle.
  - s_ready=1 only when bit_idx==DATA_W-1.
  - If a handshake occurs on that last cycle, reload and stay in SHIFT with bit_idx=0. This gives gapless streaming: exactly DATA_W cycles per word.
  - Otherwise return to IDLE.
- Detector history persists across words and idle gaps, so matches may span word boundaries. The history is cleared only by rst, clr, or a match when cfg_overlap=0.
- Match condition: {last PAT_W-1 bits, current bit}==PAT and at least PAT_W-1 valid history bits are present.
  - Evaluated combinationally on the serial bit in cycle t.
  - det_pulse and det_pos are registered and visible in cycle t+1.
  - match_cnt updates on the same edge.
- Non-overlap mode: on a match, the valid-history count resets to 0, so the next match needs PAT_W fresh bits.
- match_cnt saturates at 2^CNT_W-1 and does not wrap.
- irq is set on the edge where the new match_cnt == cfg_thresh (thresh≠0). It stays set until clr or rst, including through saturation.
- clr: clears match_cnt, irq and detector history on the next edge.
  - A match in the same cycle is discarded: clr wins, and det_pulse for that match is suppressed.
  - clr does not abort the word being shifted or change FSM state.
- cfg_overlap and cfg_thresh are sampled every cycle. Changing them mid-word takes effect on the next bit.
- No bits are shifted in IDLE, and det_pulse stays 0 there.

Decomposition:
- Shared package pattern_stream_pkg holds:
  - FSM state enum (IDLE, SHIFT);
  - the default PAT and DATA_W constants;
  - a clog2 function for det_pos width.
- One sub-module, pattern_match_core (params PAT_W, PAT):
  - inputs: bit_in, bit_en, overlap, clr;
  - outputs: match (combinational);
  - contains the history shift register and valid-history counter.
- The controller holds the FSM, serializer, counter and irq.

Test Plan:
1. Overlap=1, single word 0xAA, idle before and after → 3 det_pulses with det_pos 3,5,7; match_cnt=3; s_ready low for cycles 1..7 of the word.
2. Overlap=0, word 0xAA after clr → 2 pulses (det_pos 3,7), match_cnt=2.
3. Boundary span: words 0x01 then 0x40 back-to-back → exactly 1 pulse, det_pos=2 in the second word; s_valid held high gives 16 consecutive busy cycles with no gap.
4. Threshold: cfg_thresh=3, overlap=1, stream 0xAA,0xAA → irq rises together with the 3rd det_pulse and stays high; then pulse clr → irq=0, match_cnt=0 next cycle. clr coincident with a match → no increment.
5. Async reset mid-word: drop rst at bit_idx=4 of 0xAA → all outputs 0 immediately with no clk edge. After release, state is IDLE and the first new word 0x0A gives 1 pulse at det_pos 7 (no stale history).
6. Saturation: stream 70 words of 0xAA, overlap=1, thresh=0 → match_cnt sticks at 255, det_pulse keeps firing, irq stays 0.
